// File: rtl/wb_pkg.sv
// Shared types for the Wishbone classic master controller.
//   rsp_code_e : completion code returned with every response
//   state_e    : controller FSM states
//   cnt_w()    : counter width able to hold 0..max_val, never below 1 bit
package wb_pkg;

  typedef enum logic [1:0] {
    RSP_OK       = 2'd0,
    RSP_ERR      = 2'd1,
    RSP_RTY_FAIL = 2'd2,
    RSP_TIMEOUT  = 2'd3
  } rsp_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUS,
    ST_BACKOFF,
    ST_RESP
  } state_e;

  function automatic int unsigned cnt_w(input int unsigned max_val);
    int unsigned w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus-phase watchdog for the Wishbone master.
//   clk, nrst : clock, asynchronous active-low reset
//   clear     : synchronous clear (held while the master is not in a bus phase)
//   enable    : count one bus cycle without termination
//   expired   : the current bus cycle is cycle LIMIT of the phase
// The count saturates at LIMIT-1 so it can never wrap.
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int unsigned LIMIT = 256
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = cnt_w(LIMIT);

  logic [CW-1:0] r_cnt;
  logic          w_at_limit;

  assign w_at_limit = (r_cnt == CW'(LIMIT - 1));
  assign expired    = enable && w_at_limit;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (enable && !w_at_limit) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone classic single-transfer master with retry and timeout.
//   clk, nrst                          : clock, asynchronous active-low reset
//   req_valid/req_ready                : command handshake (ready only in IDLE)
//   req_we/req_adr/req_dat/req_sel     : command fields, captured on accept
//   rsp_valid/rsp_ready                : response handshake
//   rsp_dat/rsp_code                   : read data and completion code
//   wb_cyc/wb_stb/wb_we/wb_adr/
//   wb_dat_o/wb_sel                    : Wishbone master outputs (registered)
//   wb_dat_i/wb_ack/wb_err/wb_rty      : Wishbone slave inputs
module wb_master_ctrl
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SEL_W       = DATA_W / 8,
  parameter int unsigned TIMEOUT_CYC = 256,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_adr,
  input  logic [DATA_W-1:0] req_dat,
  input  logic [SEL_W-1:0]  req_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_dat,
  output logic [1:0]        rsp_code,
  output logic              wb_cyc,
  output logic              wb_stb,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_adr,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic [SEL_W-1:0]  wb_sel,
  input  logic [DATA_W-1:0] wb_dat_i,
  input  logic              wb_ack,
  input  logic              wb_err,
  input  logic              wb_rty
);

  localparam int unsigned RETRY_W = cnt_w(MAX_RETRY);

  state_e               r_state;
  logic [RETRY_W-1:0]   r_retry_cnt;
  logic                 r_req_ready;
  logic                 r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_dat;
  rsp_code_e            r_rsp_code;
  logic                 r_cyc;
  logic                 r_stb;
  logic                 r_we;
  logic [ADDR_W-1:0]    r_adr;
  logic [DATA_W-1:0]    r_dat_o;
  logic [SEL_W-1:0]     r_sel;

  logic                 w_in_bus;
  logic                 w_tmo_clear;
  logic                 w_tmo_expired;

  assign w_in_bus    = (r_state == ST_BUS);
  assign w_tmo_clear = !w_in_bus;

  // Cleared outside BUS so every bus phase (including after a backoff)
  // starts its own timeout window.
  wb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (w_tmo_clear),
    .enable  (w_in_bus),
    .expired (w_tmo_expired)
  );

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state     <= ST_IDLE;
      r_retry_cnt <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_code  <= RSP_OK;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat_o     <= '0;
      r_sel       <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_adr       <= req_adr;
            r_dat_o     <= req_dat;
            r_sel       <= req_sel;
            r_cyc       <= 1'b1;
            r_stb       <= 1'b1;
            r_req_ready <= 1'b0;
            r_state     <= ST_BUS;
          end
        end

        ST_BUS: begin
          // Priority ack > err > rty > timeout; a termination in the
          // final timeout cycle therefore still completes normally.
          if (wb_ack) begin
            if (!r_we) begin
              r_rsp_dat <= wb_dat_i;
            end
            r_rsp_code  <= RSP_OK;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (wb_err) begin
            r_rsp_code  <= RSP_ERR;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end else if (wb_rty) begin
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            if (r_retry_cnt < RETRY_W'(MAX_RETRY)) begin
              r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
              r_state     <= ST_BACKOFF;
            end else begin
              r_rsp_code  <= RSP_RTY_FAIL;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end
          end else if (w_tmo_expired) begin
            r_rsp_code  <= RSP_TIMEOUT;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end

        ST_BACKOFF: begin
          r_cyc   <= 1'b1;
          r_stb   <= 1'b1;
          r_state <= ST_BUS;
        end

        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_retry_cnt <= '0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_dat   = r_rsp_dat;
  assign rsp_code  = r_rsp_code;
  assign wb_cyc    = r_cyc;
  assign wb_stb    = r_stb;
  assign wb_we     = r_we;
  assign wb_adr    = r_adr;
  assign wb_dat_o  = r_dat_o;
  assign wb_sel    = r_sel;

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Bench for wb_master_ctrl: builds a cycle-by-cycle schedule of stimulus and
// expected outputs from transaction-level rules (phase lengths, termination
// priority, retry budget, timeout window), then plays it and compares.
module tb_wb_master_ctrl;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SW   = 4;
  localparam int TMO  = 8;
  localparam int MAXR = 3;

  localparam int K_ACK = 0, K_ERR = 1, K_RTY = 2, K_SIL = 3,
                 K_AE  = 4, K_AER = 5, K_ER  = 6;

  logic          clk = 1'b0;
  logic          nrst;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_adr;
  logic [DW-1:0] req_dat;
  logic [SW-1:0] req_sel;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_dat;
  logic [1:0]    rsp_code;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [SW-1:0] wb_sel;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack, wb_err, wb_rty;

  always #5 clk = ~clk;

  wb_master_ctrl #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .SEL_W       (SW),
    .TIMEOUT_CYC (TMO),
    .MAX_RETRY   (MAXR)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_adr   (req_adr),
    .req_dat   (req_dat),
    .req_sel   (req_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_code  (rsp_code),
    .wb_cyc    (wb_cyc),
    .wb_stb    (wb_stb),
    .wb_we     (wb_we),
    .wb_adr    (wb_adr),
    .wb_dat_o  (wb_dat_o),
    .wb_sel    (wb_sel),
    .wb_dat_i  (wb_dat_i),
    .wb_ack    (wb_ack),
    .wb_err    (wb_err),
    .wb_rty    (wb_rty)
  );

  typedef struct {
    logic          nrst, req_valid, req_we, rsp_ready, ack, err, rty;
    logic [AW-1:0] req_adr;
    logic [DW-1:0] req_dat, dat_i;
    logic [SW-1:0] req_sel;
    logic          e_req_ready, e_cyc, e_rsp_valid;
    logic          chk_bus, chk_rsp, chk_reset;
    logic          e_we;
    logic [AW-1:0] e_adr;
    logic [DW-1:0] e_dat;
    logic [SW-1:0] e_sel;
    logic [1:0]    e_code;
    logic [DW-1:0] e_rdat;
    int            seg;
    int            off;
  } cyc_t;

  cyc_t          sched[$];
  cyc_t          cur;
  bit            have_cur = 1'b0;
  int            n_pass = 0, n_total = 0, ncyc = 0;
  logic [DW-1:0] m_rdat = '0;
  int            seg_cur = 0;

  logic          t_we;
  logic [AW-1:0] t_adr;
  logic [DW-1:0] t_dat, t_dat_i;
  logic [SW-1:0] t_sel;
  int            t_hold, t_idle;
  int            ph_kind[4];
  int            ph_wait[4];

  int            obs_cyc[16], obs_rise[16], obs_rv[16], obs_rvfirst[16];
  logic [1:0]    obs_code[16];
  logic [DW-1:0] obs_rdat[16];
  logic          prev_cyc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, ncyc, act, exp);
  endtask

  // Default cycle: idle-ish expectations, junk on every input that must be ignored.
  function automatic cyc_t blank();
    cyc_t c;
    c.nrst = 1'b1; c.req_valid = 1'b0;
    c.req_we = 1'($urandom); c.req_adr = $urandom; c.req_dat = $urandom;
    c.req_sel = SW'($urandom); c.rsp_ready = 1'($urandom);
    c.ack = 1'($urandom); c.err = 1'($urandom); c.rty = 1'($urandom);
    c.dat_i = $urandom;
    c.e_req_ready = 1'b0; c.e_cyc = 1'b0; c.e_rsp_valid = 1'b0;
    c.chk_bus = 1'b0; c.chk_rsp = 1'b0; c.chk_reset = 1'b0;
    c.e_we = 1'b0; c.e_adr = '0; c.e_dat = '0; c.e_sel = '0;
    c.e_code = 2'd0; c.e_rdat = '0;
    c.seg = seg_cur; c.off = -1;
    return c;
  endfunction

  // n cycles in reset, then one release cycle still showing reset values.
  task automatic add_reset(input int n);
    cyc_t c;
    for (int i = 0; i <= n; i++) begin
      c = blank();
      c.nrst = (i < n) ? 1'b0 : 1'b1;
      c.chk_reset = 1'b1;
      sched.push_back(c);
    end
    m_rdat = '0;
  endtask

  task automatic add_idle(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank();
      c.e_req_ready = 1'b1;
      sched.push_back(c);
    end
  endtask

  task automatic add_txn(input int abort);
    cyc_t     c;
    int       off, retries, p, kind, len;
    bit       done;
    logic [1:0] code;
    add_idle(t_idle);
    c = blank();
    c.req_valid = 1'b1; c.req_we = t_we; c.req_adr = t_adr;
    c.req_dat = t_dat; c.req_sel = t_sel;
    c.e_req_ready = 1'b1; c.off = 0;
    sched.push_back(c);
    off = 1; retries = 0; p = 0; done = 1'b0; code = 2'd0;
    while (!done) begin
      kind = ph_kind[p];
      len  = (kind == K_SIL) ? TMO : ph_wait[p] + 1;
      for (int i = 0; i < len; i++) begin
        if (abort >= 0 && p == 0 && i == abort) begin
          add_reset(3);
          return;
        end
        c = blank();
        c.ack = 1'b0; c.err = 1'b0; c.rty = 1'b0;
        c.req_valid = 1'($urandom);
        c.e_cyc = 1'b1; c.chk_bus = 1'b1;
        c.e_we = t_we; c.e_adr = t_adr; c.e_dat = t_dat; c.e_sel = t_sel;
        c.off = off; off++;
        if (i == len - 1 && kind != K_SIL) begin
          c.ack = (kind == K_ACK || kind == K_AE || kind == K_AER);
          c.err = (kind == K_ERR || kind == K_AE || kind == K_AER || kind == K_ER);
          c.rty = (kind == K_RTY || kind == K_AER || kind == K_ER);
          c.dat_i = t_dat_i;
        end
        sched.push_back(c);
      end
      if (kind == K_SIL) begin
        code = 2'd3; done = 1'b1;
      end else if (kind == K_ACK || kind == K_AE || kind == K_AER) begin
        code = 2'd0; done = 1'b1;
        if (!t_we) m_rdat = t_dat_i;
      end else if (kind == K_ERR || kind == K_ER) begin
        code = 2'd1; done = 1'b1;
      end else if (retries < MAXR) begin
        retries++; p++;
        c = blank(); c.off = off; off++;
        sched.push_back(c);
      end else begin
        code = 2'd2; done = 1'b1;
      end
    end
    for (int h = 0; h <= t_hold; h++) begin
      c = blank();
      c.e_rsp_valid = 1'b1; c.chk_rsp = 1'b1;
      c.e_code = code; c.e_rdat = m_rdat;
      c.rsp_ready = (h == t_hold);
      c.off = off; off++;
      sched.push_back(c);
    end
  endtask

  task automatic set_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                         input logic [SW-1:0] sel, input logic [DW-1:0] dat_i,
                         input int hold, input int idle);
    t_we = we; t_adr = adr; t_dat = dat; t_sel = sel; t_dat_i = dat_i;
    t_hold = hold; t_idle = idle;
  endtask

  always @(negedge clk) begin
    if (have_cur) begin
      ncyc++;
      chk("req_ready", 32'(req_ready), 32'(cur.e_req_ready));
      chk("wb_cyc",    32'(wb_cyc),    32'(cur.e_cyc));
      chk("wb_stb",    32'(wb_stb),    32'(cur.e_cyc));
      chk("rsp_valid", 32'(rsp_valid), 32'(cur.e_rsp_valid));
      if (cur.chk_bus) begin
        chk("wb_we",    32'(wb_we),  32'(cur.e_we));
        chk("wb_adr",   wb_adr,      cur.e_adr);
        chk("wb_dat_o", wb_dat_o,    cur.e_dat);
        chk("wb_sel",   32'(wb_sel), 32'(cur.e_sel));
      end
      if (cur.chk_rsp) begin
        chk("rsp_code", 32'(rsp_code), 32'(cur.e_code));
        chk("rsp_dat",  rsp_dat,       cur.e_rdat);
      end
      if (cur.chk_reset) begin
        chk("rst_wb_we",    32'(wb_we),    32'd0);
        chk("rst_wb_adr",   wb_adr,        32'd0);
        chk("rst_wb_dat_o", wb_dat_o,      32'd0);
        chk("rst_wb_sel",   32'(wb_sel),   32'd0);
        chk("rst_rsp_dat",  rsp_dat,       32'd0);
        chk("rst_rsp_code", 32'(rsp_code), 32'd0);
      end
      if (wb_cyc) obs_cyc[cur.seg]++;
      if (wb_cyc && !prev_cyc) obs_rise[cur.seg]++;
      prev_cyc = wb_cyc;
      if (rsp_valid) begin
        obs_rv[cur.seg]++;
        if (obs_rvfirst[cur.seg] < 0) obs_rvfirst[cur.seg] = cur.off;
        obs_code[cur.seg] = rsp_code;
        obs_rdat[cur.seg] = rsp_dat;
      end
    end
  end

  initial begin
    int r;
    nrst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_dat = '0;
    req_sel = '0; rsp_ready = 1'b0; wb_dat_i = '0; wb_ack = 1'b0;
    wb_err = 1'b0; wb_rty = 1'b0;
    for (int i = 0; i < 16; i++) begin
      obs_cyc[i] = 0; obs_rise[i] = 0; obs_rv[i] = 0; obs_rvfirst[i] = -1;
      obs_code[i] = 2'd0; obs_rdat[i] = '0;
    end

    seg_cur = 0;
    add_reset(2);

    // Write, zero-wait ack.
    seg_cur = 1;
    set_txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0BAD0BAD, 0, 1);
    ph_kind[0] = K_ACK; ph_wait[0] = 0;
    add_txn(-1);
    // Read, ack after 3 wait cycles.
    seg_cur = 2;
    set_txn(1'b0, 32'h20, 32'h0, 4'hF, 32'h12345678, 0, 0);
    ph_kind[0] = K_ACK; ph_wait[0] = 3;
    add_txn(-1);
    // Slave always retries.
    seg_cur = 3;
    set_txn(1'b0, 32'h30, 32'h0, 4'h3, 32'h55AA55AA, 0, 1);
    for (int p = 0; p < 4; p++) begin ph_kind[p] = K_RTY; ph_wait[p] = 0; end
    add_txn(-1);
    // Silent slave: timeout.
    seg_cur = 4;
    set_txn(1'b1, 32'h40, 32'h11112222, 4'h1, 32'h0, 0, 0);
    ph_kind[0] = K_SIL; ph_wait[0] = 0;
    add_txn(-1);
    // ack+err in the last timeout cycle.
    seg_cur = 5;
    set_txn(1'b0, 32'h50, 32'h0, 4'hF, 32'hCAFEF00D, 0, 0);
    ph_kind[0] = K_AE; ph_wait[0] = TMO - 1;
    add_txn(-1);
    // Response held for 5 cycles.
    seg_cur = 6;
    set_txn(1'b0, 32'h60, 32'h0, 4'hF, 32'hA5A5A5A5, 5, 0);
    ph_kind[0] = K_ACK; ph_wait[0] = 2;
    add_txn(-1);
    // Reset mid-bus.
    seg_cur = 7;
    set_txn(1'b1, 32'h70, 32'h77777777, 4'hF, 32'h0, 0, 0);
    ph_kind[0] = K_SIL; ph_wait[0] = 0;
    add_txn(3);
    // Next command after reset.
    seg_cur = 8;
    set_txn(1'b1, 32'h80, 32'h88888888, 4'hC, 32'h0, 0, 0);
    ph_kind[0] = K_ACK; ph_wait[0] = 1;
    add_txn(-1);

    seg_cur = 0;
    for (int n = 0; n < 40; n++) begin
      set_txn(1'($urandom), $urandom, $urandom, SW'($urandom), $urandom,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      for (int p = 0; p < 4; p++) begin
        r = int'($urandom_range(0, 9));
        if (r <= 2)      ph_kind[p] = K_ACK;
        else if (r == 3) ph_kind[p] = K_ERR;
        else if (r <= 6) ph_kind[p] = K_RTY;
        else if (r == 7) ph_kind[p] = K_SIL;
        else if (r == 8) ph_kind[p] = K_AE;
        else             ph_kind[p] = ($urandom_range(0, 1) == 0) ? K_AER : K_ER;
        ph_wait[p] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO - 1))
                                                 : int'($urandom_range(0, 2));
      end
      add_txn(($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : -1);
    end

    foreach (sched[i]) begin
      @(posedge clk);
      #1;
      nrst      = sched[i].nrst;
      req_valid = sched[i].req_valid;
      req_we    = sched[i].req_we;
      req_adr   = sched[i].req_adr;
      req_dat   = sched[i].req_dat;
      req_sel   = sched[i].req_sel;
      rsp_ready = sched[i].rsp_ready;
      wb_ack    = sched[i].ack;
      wb_err    = sched[i].err;
      wb_rty    = sched[i].rty;
      wb_dat_i  = sched[i].dat_i;
      cur       = sched[i];
      have_cur  = 1'b1;
    end
    @(posedge clk);
    #1;
    have_cur = 1'b0;

    chk("w0_cyc_cycles",   32'(obs_cyc[1]),     32'd1);
    chk("w0_rsp_latency",  32'(obs_rvfirst[1]), 32'd2);
    chk("w0_code",         32'(obs_code[1]),    32'd0);
    chk("r3_cyc_cycles",   32'(obs_cyc[2]),     32'd4);
    chk("r3_rdat",         obs_rdat[2],         32'h12345678);
    chk("r3_code",         32'(obs_code[2]),    32'd0);
    chk("rty_phases",      32'(obs_rise[3]),    32'd4);
    chk("rty_cyc_cycles",  32'(obs_cyc[3]),     32'd4);
    chk("rty_code",        32'(obs_code[3]),    32'd2);
    chk("tmo_cyc_cycles",  32'(obs_cyc[4]),     32'd8);
    chk("tmo_code",        32'(obs_code[4]),    32'd3);
    chk("tmo_ack_cycles",  32'(obs_cyc[5]),     32'd8);
    chk("tmo_ack_code",    32'(obs_code[5]),    32'd0);
    chk("tmo_ack_rdat",    obs_rdat[5],         32'hCAFEF00D);
    chk("hold_rv_cycles",  32'(obs_rv[6]),      32'd6);
    chk("abort_rv_cycles", 32'(obs_rv[7]),      32'd0);
    chk("abort_cyc",       32'(obs_cyc[7]),     32'd3);
    chk("post_rst_cyc",    32'(obs_cyc[8]),     32'd2);
    chk("post_rst_code",   32'(obs_code[8]),    32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
